// File: rtl/config_sr_writer.sv
// config_sr_writer: host-side serializer for the chip configuration shift
// register. Each request shifts a static or dynamic word MSB-first under a
// divided serial clock, sequences SEL so the chip shadow latch captures it,
// and reads back the previous chain contents from SDO.
module config_sr_writer #(
    parameter int unsigned SIZESRSTAT = 88,
    parameter int unsigned SIZESRDYN  = 16,
    parameter int unsigned CLKDIV     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_stat,
    input  logic                  i_wr_dyn,
    input  logic [SIZESRSTAT-1:0] i_stat_data,
    input  logic [SIZESRDYN-1:0]  i_dyn_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_sel,
    output logic                  o_sr_sdi,
    input  logic                  i_sr_sdo,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [SIZESRSTAT-1:0] o_rb_data,
    output logic                  o_rb_dyn,
    output logic                  o_rb_valid
);

    localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned CNT_W = $clog2(SIZESRSTAT + 1);
    localparam int unsigned PAD_W = SIZESRSTAT - SIZESRDYN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_HOLD,
        S_LATCH,
        S_FIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [DIV_W-1:0]        r_div;
    logic [CNT_W-1:0]        r_bitcnt;
    logic [SIZESRSTAT-1:0]   r_buf;
    logic [SIZESRSTAT-1:0]   r_rb_sh;
    logic                    r_tgt_dyn;

    logic                    r_stat_pend;
    logic [SIZESRSTAT-1:0]   r_stat_data;
    logic                    r_dyn_pend;
    logic [SIZESRDYN-1:0]    r_dyn_data;

    logic                    r_sr_clk;
    logic                    r_sr_sel;
    logic                    r_sr_sdi;
    logic                    r_busy;
    logic                    r_done;
    logic [SIZESRSTAT-1:0]   r_rb_data;
    logic                    r_rb_dyn;
    logic                    r_rb_valid;

    logic                    w_div_last;
    logic                    w_bit_last;
    logic                    w_stat_go;
    logic                    w_dyn_go;
    logic                    w_launch;
    logic                    w_shift_edge;
    logic                    w_tgt_nxt;
    logic [SIZESRSTAT-1:0]   w_stat_word;
    logic [SIZESRDYN-1:0]    w_dyn_word;
    logic [SIZESRSTAT-1:0]   w_launch_word;

    logic                    w_sr_clk_nxt;
    logic                    w_sr_sel_nxt;
    logic                    w_sr_sdi_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic [SIZESRSTAT-1:0]   w_rb_data_nxt;
    logic                    w_rb_dyn_nxt;

    // Phase timing, launch arbitration and launch word selection
    always_comb begin
        w_div_last    = (r_div == DIV_W'(CLKDIV - 1));
        w_bit_last    = r_tgt_dyn ? (r_bitcnt == CNT_W'(SIZESRDYN))
                                  : (r_bitcnt == CNT_W'(SIZESRSTAT));
        w_stat_go     = (r_state == S_IDLE) && (r_stat_pend || i_wr_stat);
        w_dyn_go      = (r_state == S_IDLE) && !w_stat_go && (r_dyn_pend || i_wr_dyn);
        w_launch      = w_stat_go || w_dyn_go;
        // A request arriving in the launch cycle is newer than the slot
        w_stat_word   = i_wr_stat ? i_stat_data : r_stat_data;
        w_dyn_word    = i_wr_dyn  ? i_dyn_data  : r_dyn_data;
        w_launch_word = w_stat_go ? w_stat_word : {w_dyn_word, {PAD_W{1'b0}}};
        w_tgt_nxt     = w_stat_go ? 1'b0 : (w_dyn_go ? 1'b1 : r_tgt_dyn);
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_div_last) begin
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (w_div_last) begin
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_div_last) begin
                    w_state_nxt = w_bit_last ? S_HOLD : S_SHIFT_LO;
                end
            end
            S_HOLD: begin
                if (w_div_last) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (w_div_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_shift_edge = (r_state == S_SHIFT_LO) && (w_state_nxt == S_SHIFT_HI);
    end

    // FSM output decode: next values of the registered pad and status outputs
    always_comb begin
        w_sr_clk_nxt  = 1'b0;
        w_sr_sel_nxt  = 1'b0;
        w_sr_sdi_nxt  = r_sr_sdi;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_rb_data_nxt = r_rb_data;
        w_rb_dyn_nxt  = r_rb_dyn;
        case (w_state_nxt)
            S_SETUP: begin
                w_sr_sel_nxt = w_tgt_nxt;
                w_busy_nxt   = 1'b1;
            end
            S_SHIFT_LO: begin
                w_sr_sel_nxt = w_tgt_nxt;
                w_busy_nxt   = 1'b1;
                // SDI moves only on entry so it is stable around the rise
                if (r_state != S_SHIFT_LO) begin
                    w_sr_sdi_nxt = r_buf[SIZESRSTAT-1];
                end
            end
            S_SHIFT_HI: begin
                w_sr_clk_nxt = 1'b1;
                w_sr_sel_nxt = w_tgt_nxt;
                w_busy_nxt   = 1'b1;
            end
            S_HOLD: begin
                w_sr_sel_nxt = w_tgt_nxt;
                w_busy_nxt   = 1'b1;
            end
            S_LATCH: begin
                w_sr_sel_nxt = !w_tgt_nxt;
                w_busy_nxt   = 1'b1;
            end
            S_FIN: begin
                w_done_nxt    = 1'b1;
                w_rb_data_nxt = r_rb_sh;
                w_rb_dyn_nxt  = r_tgt_dyn;
            end
            default: begin
                w_sr_sel_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr_clk   <= 1'b0;
            r_sr_sel   <= 1'b0;
            r_sr_sdi   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rb_data  <= '0;
            r_rb_dyn   <= 1'b0;
            r_rb_valid <= 1'b0;
        end else begin
            r_sr_clk   <= w_sr_clk_nxt;
            r_sr_sel   <= w_sr_sel_nxt;
            r_sr_sdi   <= w_sr_sdi_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_rb_data  <= w_rb_data_nxt;
            r_rb_dyn   <= w_rb_dyn_nxt;
            r_rb_valid <= w_done_nxt;
        end
    end

    // Per-phase divider: restarts on every state change
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Shift buffer, readback shifter, bit counter and target
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf     <= '0;
            r_rb_sh   <= '0;
            r_bitcnt  <= '0;
            r_tgt_dyn <= 1'b0;
        end else if (w_launch) begin
            r_buf     <= w_launch_word;
            r_rb_sh   <= '0;
            r_bitcnt  <= '0;
            r_tgt_dyn <= w_dyn_go;
        end else if (w_shift_edge) begin
            r_buf   <= {r_buf[SIZESRSTAT-2:0], 1'b0};
            r_rb_sh <= {r_rb_sh[SIZESRSTAT-2:0], i_sr_sdo};
            if (!w_bit_last) begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
        end
    end

    // Static pending slot: last request wins, cleared on launch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_pend <= 1'b0;
            r_stat_data <= '0;
        end else if (w_stat_go) begin
            r_stat_pend <= 1'b0;
        end else if (i_wr_stat) begin
            r_stat_pend <= 1'b1;
            r_stat_data <= i_stat_data;
        end
    end

    // Dynamic pending slot: last request wins, cleared on launch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dyn_pend <= 1'b0;
            r_dyn_data <= '0;
        end else if (w_dyn_go) begin
            r_dyn_pend <= 1'b0;
        end else if (i_wr_dyn) begin
            r_dyn_pend <= 1'b1;
            r_dyn_data <= i_dyn_data;
        end
    end

    assign o_sr_clk   = r_sr_clk;
    assign o_sr_sel   = r_sr_sel;
    assign o_sr_sdi   = r_sr_sdi;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rb_data  = r_rb_data;
    assign o_rb_dyn   = r_rb_dyn;
    assign o_rb_valid = r_rb_valid;

endmodule

// File: tb/tb_config_sr_writer.sv
// Bench for config_sr_writer: a chip-side chain model sits on the pads, a
// scoreboard queue holds the expected readback per transfer and a monitor
// checks each DONE against it.
module tb_config_sr_writer;

    localparam int unsigned NS = 88;
    localparam int unsigned ND = 16;
    localparam int unsigned D  = 2;
    // D*(2N+3)+1 with D=2
    localparam int unsigned T_STAT = 359;
    localparam int unsigned T_DYN  = 71;

    localparam logic [NS-1:0] STAT_DEF = 88'hC3_0F1E_2D3C_4B5A_6978_8796;
    localparam logic [ND-1:0] DYN_DEF  = 16'h4000;

    localparam logic [NS-1:0] S1 = 88'h00A5_5A5A_5A5A_5A5A_5A5A;
    localparam logic [NS-1:0] S2 = 88'hFE_DCBA_9876_5432_10F0_0F11;
    localparam logic [NS-1:0] S3 = 88'h80_0000_0000_0000_0000_0001;
    localparam logic [NS-1:0] S4 = 88'h5A_0123_4567_89AB_CDEF_0F1E;
    localparam logic [ND-1:0] D2 = 16'h3C96;

    typedef struct packed {
        logic [NS-1:0] rb;
        logic          dyn;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_stat = 1'b0;
    logic          wr_dyn = 1'b0;
    logic [NS-1:0] stat_data = '0;
    logic [ND-1:0] dyn_data = '0;
    logic          sr_clk, sr_sel, sr_sdi, sr_sdo;
    logic          busy, done, rb_dyn, rb_valid;
    logic [NS-1:0] rb_data;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rises = 0;
    int   selhi = 0;
    int   busyc = 0;
    exp_t sb[$];

    // Chip-side model: two chains selected by SEL, static shadow transparent
    // while SEL is high, dynamic shadow captured on SEL falling
    logic [NS-1:0] stat_chain = STAT_DEF;
    logic [ND-1:0] dyn_chain  = DYN_DEF;
    logic [NS-1:0] statcnf    = STAT_DEF;
    logic [ND-1:0] dyncnf     = DYN_DEF;

    assign sr_sdo = sr_sel ? dyn_chain[ND-1] : stat_chain[NS-1];

    always @(posedge sr_clk) begin
        if (sr_sel) dyn_chain <= {dyn_chain[ND-2:0], sr_sdi};
        else        stat_chain <= {stat_chain[NS-2:0], sr_sdi};
    end

    always @(posedge clk) begin
        if (sr_sel) statcnf <= stat_chain;
    end

    always @(negedge sr_sel) begin
        dyncnf <= dyn_chain;
    end

    config_sr_writer #(
        .SIZESRSTAT(NS),
        .SIZESRDYN (ND),
        .CLKDIV    (D)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_stat  (wr_stat),
        .i_wr_dyn   (wr_dyn),
        .i_stat_data(stat_data),
        .i_dyn_data (dyn_data),
        .o_sr_clk   (sr_clk),
        .o_sr_sel   (sr_sel),
        .o_sr_sdi   (sr_sdi),
        .i_sr_sdo   (sr_sdo),
        .o_busy     (busy),
        .o_done     (done),
        .o_rb_data  (rb_data),
        .o_rb_dyn   (rb_dyn),
        .o_rb_valid (rb_valid)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge sr_clk);
        rises++;
    end

    initial forever begin
        @(negedge clk);
        if (sr_sel === 1'b1) selhi++;
        if (busy === 1'b1) busyc++;
    end

    task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every DONE/RB_VALID pops one expectation
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done === 1'b1 || rb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", NS'({done, rb_valid}), NS'(0));
            end else begin
                e = sb.pop_front();
                chk("rb_data", rb_data, e.rb);
                chk("rb_dyn", NS'(rb_dyn), NS'(e.dyn));
                chk("done_cycle", NS'(cyc), NS'(e.cyc));
                chk("done_with_rb_valid", NS'({done, rb_valid}), NS'(2'b11));
            end
        end
    end

    task automatic expect_rb(input logic [NS-1:0] rb, input logic dyn, input int at);
        exp_t e;
        e.rb  = rb;
        e.dyn = dyn;
        e.cyc = 32'(at);
        sb.push_back(e);
    endtask

    // Called right after a negedge; request is high for one clock
    task automatic pulse(input logic ws, input logic wd, input logic [NS-1:0] sd, input logic [ND-1:0] dd);
        wr_stat   = ws;
        wr_dyn    = wd;
        stat_data = sd;
        dyn_data  = dd;
        @(negedge clk);
        wr_stat = 1'b0;
        wr_dyn  = 1'b0;
    endtask

    task automatic wait_sb(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", NS'(sb.size()), NS'(0));
    endtask

    initial begin
        int k, r0, s0, b0, n;
        logic [31:0] cat;

        // Reset with requests presented during it
        @(negedge clk);
        pulse(1'b1, 1'b1, S1, 16'hFFFF);
        @(negedge clk);
        chk("rst_ctrl", NS'({sr_clk, sr_sel, sr_sdi, busy, done, rb_dyn, rb_valid}), NS'(0));
        chk("rst_rb_data", rb_data, NS'(0));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_sr_clk", NS'(rises), NS'(0));
        chk("rst_wr_dropped_busy", NS'(busy), NS'(0));

        // Static write
        r0 = rises; s0 = selhi; b0 = busyc; k = cyc;
        expect_rb(STAT_DEF, 1'b0, k + T_STAT);
        pulse(1'b1, 1'b0, S1, '0);
        wait_sb(1000);
        chk("stat_cnf", statcnf, S1);
        chk("stat_rises", NS'(rises - r0), NS'(88));
        chk("stat_sel_high", NS'(selhi - s0), NS'(2));
        chk("stat_busy_cycles", NS'(busyc - b0), NS'(358));
        repeat (5) @(negedge clk);

        // Dynamic writes
        r0 = rises; k = cyc;
        expect_rb(NS'(16'h4000), 1'b1, k + T_DYN);
        pulse(1'b0, 1'b1, '0, 16'hA5C3);
        wait_sb(1000);
        chk("dyn_cnf_1", NS'(dyncnf), NS'(16'hA5C3));
        chk("dyn_rises", NS'(rises - r0), NS'(16));
        repeat (3) @(negedge clk);
        k = cyc;
        expect_rb(NS'(16'hA5C3), 1'b1, k + T_DYN);
        pulse(1'b0, 1'b1, '0, 16'h1234);
        wait_sb(1000);
        chk("dyn_cnf_2", NS'(dyncnf), NS'(16'h1234));
        repeat (3) @(negedge clk);

        // Simultaneous requests: static first, dynamic two cycles after DONE
        k = cyc;
        expect_rb(S1, 1'b0, k + T_STAT);
        expect_rb(NS'(16'h1234), 1'b1, k + T_STAT + 1 + T_DYN);
        pulse(1'b1, 1'b1, S2, D2);
        wait_sb(2000);
        chk("both_stat_cnf", statcnf, S2);
        chk("both_dyn_cnf", NS'(dyncnf), NS'(D2));
        repeat (3) @(negedge clk);

        // Dynamic rewritten twice while static is running: last wins
        k = cyc;
        expect_rb(S2, 1'b0, k + T_STAT);
        pulse(1'b1, 1'b0, S3, '0);
        repeat (19) @(negedge clk);
        pulse(1'b0, 1'b1, '0, 16'h1111);
        repeat (19) @(negedge clk);
        expect_rb(NS'(D2), 1'b1, k + T_STAT + 1 + T_DYN);
        pulse(1'b0, 1'b1, '0, 16'h2222);
        wait_sb(2000);
        repeat (100) @(negedge clk);
        chk("lastwins_dyn_cnf", NS'(dyncnf), NS'(16'h2222));
        chk("lastwins_idle", NS'(busy), NS'(0));

        // Abort a dynamic write at the 10th serial clock rise
        r0 = rises;
        pulse(1'b0, 1'b1, '0, 16'hBEEF);
        repeat (4) @(negedge clk);
        pulse(1'b1, 1'b0, S4, '0);
        n = 0;
        while ((rises - r0) != 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_10th_rise", NS'({rises - r0, sr_clk}), NS'({32'd10, 1'b1}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", NS'({sr_sel, sr_clk, busy, done}), NS'(0));
        repeat (300) @(negedge clk);
        chk("abort_no_more_rises", NS'(rises - r0), NS'(10));
        cat = {16'h2222, 16'hBEEF};
        chk("abort_partial_dyn", NS'(dyncnf), NS'(cat[21:6]));
        chk("abort_stat_untouched", statcnf, S3);

        // Fresh write after abort
        k = cyc;
        expect_rb(S3, 1'b0, k + T_STAT);
        pulse(1'b1, 1'b0, S4, '0);
        wait_sb(1000);
        chk("post_abort_stat_cnf", statcnf, S4);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
